phase_delta_estimator: RTL and testbench
========================================

Name: phase_delta_estimator

Overview:
- Consumes a stream of 32-bit phase samples and recovers the per-sample phase increment. Scaling: 2^32 = one full rotation.
- Typical sources: NCO phase output, or the CORDIC phase of a received tone.
- Averages wrapped sample-to-sample differences over a fixed block and outputs the mean increment, in the units the NCO accepts as its phase step.
- Used for frequency-offset measurement and for closing the loop back onto the NCO tuning word.

Parameters:
- PHASE_WIDTH, 32, width of phase samples and of the output increment.
- LOG2_AVG, 4, log2 of the number of differences averaged per output. Legal range 0..8.

Ports:
- i_adcClock  input  1  sole clock; all state updates on its rising edge.
- i_resetn  input  1  synchronous, active-low reset.
- i_clear  input  1  synchronous restart; discards the partial block and the stored sample.
- i_phaseValid  input  1  qualifies i_phaseAngle for this cycle.
- i_phaseAngle  input  PHASE_WIDTH  phase sample, unsigned rotation fraction.
- o_phaseDelta  output  PHASE_WIDTH  mean increment, two's complement (wrapped units).
- o_deltaValid  output  1  single-cycle pulse when o_phaseDelta is updated.
- o_primed  output  1  high once a reference sample is held (state ACCUM).

Behaviour:
- Reset: synchronous, active-low, sampled on the i_adcClock rising edge. It overrides i_clear and i_phaseValid.
  - Reset values: o_phaseDelta = 0, o_deltaValid = 0, o_primed = 0.
  - Internal reset values: state = EMPTY, sample counter = 0, accumulator = 0, stored previous sample = 0.
- i_clear (reset inactive): same effect as reset on state, counter, accumulator and o_primed. o_phaseDelta is held at its last value. o_deltaValid = 0 next cycle. i_clear wins over a simultaneous i_phaseValid; that sample is dropped.
- State machine, two states:
  - EMPTY: on i_phaseValid, store i_phaseAngle as prev and go to ACCUM. No difference is accumulated.
  - ACCUM: on i_phaseValid, compute diff = (i_phaseAngle - prev) mod 2^PHASE_WIDTH, read as signed. Range is -2^(PW-1) .. 2^(PW-1)-1, so 0x80000000 reads as -2^31.
  - ACCUM update on a valid sample:
    - sum += sign-extended diff;
    - prev <= i_phaseAngle;
    - counter += 1.
  - ACCUM leaves only via reset or clear.
- Accumulator width is PHASE_WIDTH+LOG2_AVG bits, signed; it never overflows.
- Block completion: on the valid sample where counter == 2^LOG2_AVG - 1:
  - o_phaseDelta <= (sum + diff) >>> LOG2_AVG. Arithmetic shift, floor rounding, low PHASE_WIDTH bits kept.
  - o_deltaValid <= 1;
  - sum <= 0, counter <= 0.
- Latency: o_deltaValid asserts in the cycle after the edge that accepts the 2^LOG2_AVG-th difference sample.
- The completing sample also becomes prev for the next block, so consecutive blocks are gapless. The first output needs 2^LOG2_AVG + 1 samples; later outputs need 2^LOG2_AVG each.
- i_phaseValid low: no state change. Gaps of any length are allowed; prev is retained across them.
- o_deltaValid is high for exactly one cycle per completed block, and is never high in two consecutive cycles unless LOG2_AVG = 0 and valid is continuous.
- LOG2_AVG = 0: every valid sample in ACCUM produces an output equal to the raw wrapped diff.
- o_phaseDelta is held between pulses.

Test Plan:
- Continuous valid, samples 0, 0x01000000, 0x02000000 ... (step 0x01000000), LOG2_AVG=4 -> first o_deltaValid one cycle after the 17th sample, o_phaseDelta = 0x01000000; next pulse exactly 16 samples later, same value.
- Wrap: start 0xF8000000, step 0x10000000 (crosses 0xFFFFFFFF->0) -> o_phaseDelta = 0x10000000, no glitch at the wrap.
- Negative step 0xFF000000 from 0x00000000 -> o_phaseDelta = 0xFF000000. Alternating steps 0x00000001 / 0x00000002 -> sum 24, output 0x00000001 (floor).
- i_phaseValid asserted every third cycle with step 0x00400000 -> output 0x00400000; pulse cycle tracks the 17th valid sample; o_primed high from the cycle after the first sample.
- i_clear asserted together with the 10th sample of a block -> o_primed=0, no pulse, o_phaseDelta unchanged. A further 17 samples are needed for the next pulse.
- i_resetn low mid-block for one cycle -> all outputs 0 next cycle. A simultaneous i_phaseValid is ignored. Recovery needs 17 samples.

Source files
------------

// File: rtl/phase_delta_estimator.sv
// phase_delta_estimator
//
// Recovers the per-sample phase increment of a stream of phase samples
// (2^PHASE_WIDTH = one full rotation). Wrapped sample-to-sample differences
// are averaged over blocks of 2^LOG2_AVG differences. The mean increment is
// presented in the same two's complement units an NCO takes as its phase step.
//
// Ports:
//   i_adcClock    sole clock, rising edge
//   i_resetn      synchronous active-low reset (overrides everything)
//   i_clear       synchronous restart: drops partial block and stored sample
//   i_phaseValid  qualifies i_phaseAngle
//   i_phaseAngle  unsigned phase sample
//   o_phaseDelta  mean increment, two's complement, held between pulses
//   o_deltaValid  one-cycle pulse when o_phaseDelta is updated
//   o_primed      high while a reference sample is held (ACCUM state)

module phase_delta_estimator #(
  parameter int PHASE_WIDTH = 32,
  parameter int LOG2_AVG    = 4
) (
  input  logic                   i_adcClock,
  input  logic                   i_resetn,
  input  logic                   i_clear,
  input  logic                   i_phaseValid,
  input  logic [PHASE_WIDTH-1:0] i_phaseAngle,
  output logic [PHASE_WIDTH-1:0] o_phaseDelta,
  output logic                   o_deltaValid,
  output logic                   o_primed
);

  // The accumulator carries LOG2_AVG guard bits, so a block of worst-case
  // differences cannot overflow it.
  localparam int ACC_W = PHASE_WIDTH + LOG2_AVG;
  localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    ACCUM = 1'b1
  } state_e;

  state_e                          state_q, state_d;
  logic        [PHASE_WIDTH-1:0]   prev_q, prev_d;
  logic signed [ACC_W-1:0]         sum_q, sum_d;
  logic        [CNT_W-1:0]         cnt_q, cnt_d;
  logic        [PHASE_WIDTH-1:0]   delta_q, delta_d;
  logic                            dvalid_q, dvalid_d;

  logic signed [PHASE_WIDTH-1:0]   diff;
  logic signed [ACC_W-1:0]         sumNext;

  // Modular subtraction gives the wrapped difference directly; reading it as
  // signed maps it onto the shortest way round the circle. Because the
  // accumulator is sign-extended, the completing block can be shifted
  // arithmetically to get a floor-rounded mean.
  always_comb begin
    diff    = $signed(i_phaseAngle - prev_q);
    sumNext = sum_q + ACC_W'(diff);
  end

  // Next-state logic: hold everything by default. Clear acts like reset,
  // except that the last published delta is kept.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    delta_d  = delta_q;
    dvalid_d = 1'b0;

    if (i_clear) begin
      state_d = EMPTY;
      prev_d  = '0;
      sum_d   = '0;
      cnt_d   = '0;
    end else if (i_phaseValid) begin
      unique case (state_q)
        EMPTY: begin
          prev_d  = i_phaseAngle;
          state_d = ACCUM;
        end
        ACCUM: begin
          // The completing sample also becomes the next reference, so
          // consecutive blocks have no gap between them.
          prev_d = i_phaseAngle;
          if (cnt_q == CNT_LAST) begin
            delta_d  = PHASE_WIDTH'(sumNext >>> LOG2_AVG);
            dvalid_d = 1'b1;
            sum_d    = '0;
            cnt_d    = '0;
          end else begin
            sum_d = sumNext;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_adcClock) begin
    if (!i_resetn) begin
      state_q  <= EMPTY;
      prev_q   <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      delta_q  <= '0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      delta_q  <= delta_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign o_phaseDelta = delta_q;
  assign o_deltaValid = dvalid_q;
  assign o_primed     = (state_q == ACCUM);

endmodule

// File: tb/tb_phase_delta_estimator.sv
// tb_phase_delta_estimator
//
// Directed bench for phase_delta_estimator (PHASE_WIDTH=32, LOG2_AVG=4).
// Expected block results, with the clock cycle they should appear in, are
// pushed to a scoreboard when the completing sample is driven. A negedge
// monitor pops and compares them when o_deltaValid fires.

module tb_phase_delta_estimator;

  localparam int PW = 32;
  localparam int LA = 4;
  localparam int NAVG = 1 << LA;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          clr = 1'b0;
  logic          valid = 1'b0;
  logic [PW-1:0] angle = '0;
  logic [PW-1:0] oDelta;
  logic          oValid;
  logic          oPrimed;

  typedef struct {
    logic [PW-1:0] val;
    int            cyc;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad = 0;
  int cycleCnt = 0;

  // Reference model state
  bit            mPrimed = 1'b0;
  logic [PW-1:0] mPrev = '0;
  longint        mSum = 0;
  int            mCnt = 0;

  phase_delta_estimator #(
    .PHASE_WIDTH(PW),
    .LOG2_AVG   (LA)
  ) dut (
    .i_adcClock  (clk),
    .i_resetn    (resetn),
    .i_clear     (clr),
    .i_phaseValid(valid),
    .i_phaseAngle(angle),
    .o_phaseDelta(oDelta),
    .o_deltaValid(oValid),
    .o_primed    (oPrimed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs and advances the reference model in step.
  task automatic applyStimulus(input logic rn, input logic c, input logic v, input logic [PW-1:0] a);
    logic signed [PW-1:0] d;
    if (!rn) begin
      mPrimed = 1'b0; mPrev = '0; mSum = 0; mCnt = 0;
    end else if (c) begin
      mPrimed = 1'b0; mPrev = '0; mSum = 0; mCnt = 0;
    end else if (v) begin
      if (!mPrimed) begin
        mPrimed = 1'b1;
        mPrev = a;
      end else begin
        d = $signed(a - mPrev);
        mSum += longint'(d);
        mPrev = a;
        mCnt++;
        if (mCnt == NAVG) begin
          sb.push_back('{val: PW'(mSum >>> LA), cyc: cycleCnt + 1});
          mSum = 0;
          mCnt = 0;
        end
      end
    end
    resetn = rn; clr = c; valid = v; angle = a;
    @(posedge clk);
    #1;
    resetn = 1'b1; clr = 1'b0; valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic ramp(input logic [PW-1:0] start, input logic [PW-1:0] step, input int n, input int gap);
    logic [PW-1:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, a);
      a = a + step;
      idle(gap);
    end
  endtask

  task automatic checkDrained(input string tag);
    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL %s pending=%0d expected=0", tag, sb.size());
    end
  endtask

  // Scoreboard monitor: overdue entries are missing pulses; a pulse with
  // nothing pending is spurious; otherwise value and cycle must match.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cycleCnt) begin
      e = sb.pop_front();
      total++;
      bad++;
      $error("FAIL missing_pulse observed=none expected=%h at cycle %0d", e.val, e.cyc);
    end
    if (oValid === 1'b1) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_pulse observed=%h expected=no pulse (cycle %0d)", oDelta, cycleCnt);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("pulse_value", oDelta, e.val);
        checkOutput("pulse_cycle", PW'(cycleCnt), PW'(e.cyc));
      end
    end
  end

  initial begin
    logic [PW-1:0] a;

    // Reset, with a valid sample that must be ignored
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1234_5678);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("reset_delta", oDelta, '0);
    checkOutput("reset_valid", PW'(oValid), '0);
    checkOutput("reset_primed", PW'(oPrimed), '0);

    // Continuous ramp: two back-to-back blocks
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0000);
    checkOutput("ramp_primed", PW'(oPrimed), 32'd1);
    ramp(32'h0100_0000, 32'h0100_0000, 2 * NAVG, 0);
    idle(2);
    checkOutput("ramp_delta", oDelta, 32'h0100_0000);
    checkDrained("ramp_drained");

    // Clear: primed drops, delta held
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("clear_primed", PW'(oPrimed), '0);
    checkOutput("clear_hold", oDelta, 32'h0100_0000);
    checkOutput("clear_valid", PW'(oValid), '0);

    // Wrap across 0xFFFFFFFF -> 0
    ramp(32'hF800_0000, 32'h1000_0000, NAVG + 1, 0);
    idle(2);
    checkOutput("wrap_delta", oDelta, 32'h1000_0000);

    // Negative step
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    ramp(32'h0000_0000, 32'hFF00_0000, NAVG + 1, 0);
    idle(2);
    checkOutput("neg_delta", oDelta, 32'hFF00_0000);

    // Alternating 1/2 steps: sum 24, floor(24/16) = 1
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    a = 32'h7FFF_FFF0;
    applyStimulus(1'b1, 1'b0, 1'b1, a);
    for (int i = 0; i < NAVG; i++) begin
      a = a + ((i % 2 == 0) ? 32'd1 : 32'd2);
      applyStimulus(1'b1, 1'b0, 1'b1, a);
    end
    idle(2);
    checkOutput("alt_delta", oDelta, 32'h0000_0001);

    // Valid every third cycle
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0000);
    checkOutput("gap_primed", PW'(oPrimed), 32'd1);
    idle(2);
    ramp(32'h0040_0000, 32'h0040_0000, NAVG, 2);
    checkOutput("gap_delta", oDelta, 32'h0040_0000);

    // Clear arriving with the 10th sample of a block
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    ramp(32'h0000_0000, 32'h0010_0000, 9, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0090_0000);
    checkOutput("midclr_primed", PW'(oPrimed), '0);
    checkOutput("midclr_hold", oDelta, 32'h0040_0000);
    checkOutput("midclr_valid", PW'(oValid), '0);
    ramp(32'h0100_0000, 32'h0010_0000, NAVG, 0);
    idle(2);
    checkOutput("midclr_nopulse_hold", oDelta, 32'h0040_0000);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0200_0000);
    idle(2);
    checkOutput("midclr_delta", oDelta, 32'h0010_0000);

    // Reset mid-block with a simultaneous valid sample
    ramp(32'h0300_0000, 32'h0001_0000, 5, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    checkOutput("midrst_delta", oDelta, '0);
    checkOutput("midrst_valid", PW'(oValid), '0);
    checkOutput("midrst_primed", PW'(oPrimed), '0);
    ramp(32'h1000_0000, 32'h0020_0000, NAVG + 1, 0);
    idle(2);
    checkOutput("midrst_recover", oDelta, 32'h0020_0000);

    idle(3);
    checkDrained("final_drained");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
